// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory load/store path.
//   - SIZE_* access size codes (same encoding as the byte-enable stage;
//     code 3 is treated as word)
//   - state_t: mem_lane_ctrl FSM state encoding
//   - lane_replicate(): copies store data across all lanes for its size
//   - extend():         zero/sign-extends a selected byte or half
//   - misaligned():     offset check used when MEM_MISALIGN_FAULT_EN is defined
package mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   // Replicate right-justified store data so every lane carries the value;
   // the per-lane write enables then pick the lanes actually written.
   function automatic logic [31:0] lane_replicate(input logic [31:0] wdata,
                                                  input logic [1:0]  size);
      case (size)
         SIZE_BYTE: return {4{wdata[7:0]}};
         SIZE_HALF: return {2{wdata[15:0]}};
         default:   return wdata;
      endcase
   endfunction

   // Extend a byte (is_byte=1, uses val[7:0]) or a half (uses val[15:0]).
   function automatic logic [31:0] extend(input logic [15:0] val,
                                          input logic        is_byte,
                                          input logic        sgn);
      logic msb;
      msb = is_byte ? val[7] : val[15];
      if (is_byte)
         return {{24{sgn & msb}}, val[7:0]};
      else
         return {{16{sgn & msb}}, val};
   endfunction

   // Half needs an even address, word needs a 4-byte-aligned address.
   function automatic logic misaligned(input logic [1:0] offset,
                                       input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return offset[0];
         default:   return |offset;
      endcase
   endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational lane extraction and extension of a RAM word.
// Ports:
//   rdata    in  32  raw RAM word
//   offset   in   2  byte offset within the word (addr[1:0])
//   size     in   2  SIZE_BYTE / SIZE_HALF / word (2 or 3)
//   sign_ext in   1  sign-extend byte/half results
//   result   out 32  extended load value
// Half selection only looks at offset[1]; word loads return rdata unchanged.
module load_extract
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

      result = rdata;
      case (size)
         SIZE_BYTE: result = extend({8'h00, byte_sel}, 1'b1, sign_ext);
         SIZE_HALF: result = extend(half_sel, 1'b0, sign_ext);
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_lane_ctrl.sv
// mem_lane_ctrl: data-memory access controller for the load/store path.
// Accepts one request per handshake, drives a one-cycle strobe to a
// synchronous word-wide RAM after WAIT_STATES idle cycles, captures and
// extends the load data, and holds it on a registered response handshake.
// Optional feature: define MEM_MISALIGN_FAULT_EN to fault misaligned
// half/word accesses without touching the RAM.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (transfer when both high)
//   req_write, req_addr, req_wdata, req_be, req_size, req_signed
//   rsp_valid/rsp_ready   response handshake (transfer when both high)
//   rsp_rdata, rsp_fault  response payload, stable while rsp_valid
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata   RAM port
//   dbg_state             current FSM state (state_t encoding)
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The requester holds its request until req_ready; the controller holds
// rsp_valid and its payload until rsp_ready, with no bound on the wait.
module mem_lane_ctrl
   import mem_pkg::*;
#(
   parameter int WAIT_STATES = 0,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic        write_q;
   logic [31:0] rdata_q;
   logic [31:0] ext_data;

`ifdef MEM_MISALIGN_FAULT_EN
   logic        fault_q;
   logic        req_misaligned;
   assign req_misaligned = misaligned(req_addr[1:0], req_size);
   assign rsp_fault      = fault_q;
`else
   assign rsp_fault      = 1'b0;
`endif

   load_extract u_load_extract (
      .rdata    (mem_rdata),
      .offset   (addr_q[1:0]),
      .size     (size_q),
      .sign_ext (signed_q),
      .result   (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
`ifdef MEM_MISALIGN_FAULT_EN
               if (req_misaligned)
                  state_d = ST_RESP;
               else
                  state_d = ST_ACCESS;
`else
               state_d = ST_ACCESS;
`endif
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               mem_en  = 1'b1;
               mem_we  = write_q ? be_q : 4'b0000;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: state_d = ST_RESP;
         ST_RESP: begin
            if (rsp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A strobe pending when reset arrives must not reach the RAM.
      if (reset) begin
         mem_en = 1'b0;
         mem_we = 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         rdata_q  <= '0;
`ifdef MEM_MISALIGN_FAULT_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  be_q     <= req_be;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  write_q  <= req_write;
                  cnt_q    <= CNT_W'(WAIT_STATES);
                  // Cleared here so a faulted response reports zero data.
                  rdata_q  <= '0;
`ifdef MEM_MISALIGN_FAULT_EN
                  fault_q  <= req_misaligned;
`endif
               end
            end
            ST_ACCESS: begin
               if (cnt_q != '0)
                  cnt_q <= cnt_q - CNT_W'(1);
            end
            ST_CAPTURE: rdata_q <= write_q ? 32'h0 : ext_data;
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign mem_addr  = addr_q[31:2];
   assign mem_wdata = (state_q != ST_IDLE) ? lane_replicate(wdata_q, size_q) : 32'h0;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Directed bench for mem_lane_ctrl. Two instances: dut_a with WAIT_STATES=0
// and dut_b with WAIT_STATES=3, sharing request payload, rsp_ready and
// reset; req_valid is routed by sel. The RAM is modelled as one word
// (ram_word) returned the cycle after each strobe.
module tb_mem_lane_ctrl;

   logic        clk;
   logic        reset;
   logic        sel;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [1:0]  req_size;
   logic        req_signed;
   logic        rsp_ready;
   logic [31:0] ram_word;

   logic        req_ready_a, rsp_valid_a, rsp_fault_a, mem_en_a;
   logic [31:0] rsp_rdata_a, mem_wdata_a;
   logic [3:0]  mem_we_a;
   logic [29:0] mem_addr_a;
   logic [1:0]  dbg_state_a;
   logic [31:0] rd_a;

   logic        req_ready_b, rsp_valid_b, rsp_fault_b, mem_en_b;
   logic [31:0] rsp_rdata_b, mem_wdata_b;
   logic [3:0]  mem_we_b;
   logic [29:0] mem_addr_b;
   logic [1:0]  dbg_state_b;
   logic [31:0] rd_b;

   logic        m_req_ready, m_rsp_valid, m_rsp_fault, m_en;
   logic [31:0] m_rsp_rdata, m_wdata;
   logic [3:0]  m_we;
   logic [29:0] m_addr;
   logic [1:0]  m_state;

   int checks = 0;
   int errors = 0;

   mem_lane_ctrl #(.WAIT_STATES(0), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & ~sel), .req_ready(req_ready_a),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_be(req_be), .req_size(req_size), .req_signed(req_signed),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_a), .rsp_fault(rsp_fault_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(rd_a), .dbg_state(dbg_state_a)
   );

   mem_lane_ctrl #(.WAIT_STATES(3), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & sel), .req_ready(req_ready_b),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_be(req_be), .req_size(req_size), .req_signed(req_signed),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_b), .rsp_fault(rsp_fault_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(rd_b), .dbg_state(dbg_state_b)
   );

   assign m_req_ready = sel ? req_ready_b : req_ready_a;
   assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
   assign m_rsp_fault = sel ? rsp_fault_b : rsp_fault_a;
   assign m_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
   assign m_en        = sel ? mem_en_b    : mem_en_a;
   assign m_we        = sel ? mem_we_b    : mem_we_a;
   assign m_addr      = sel ? mem_addr_b  : mem_addr_a;
   assign m_wdata     = sel ? mem_wdata_b : mem_wdata_a;
   assign m_state     = sel ? dbg_state_b : dbg_state_a;

   // ---------------- clock / RAM model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en_a) rd_a <= ram_word;
      if (mem_en_b) rd_b <= ram_word;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required end of test");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] ram;
      logic [3:0]  exp_we;
      logic [31:0] exp_wdata;
      logic [29:0] exp_maddr;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];

   task automatic drive_req(input vec_t v);
      req_write  = v.wr;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_be     = v.be;
      req_size   = v.size;
      req_signed = v.sgn;
      req_valid  = 1'b1;
   endtask

   // One full transaction on the selected DUT; ws is its WAIT_STATES and
   // hold is the number of cycles rsp_ready is kept low once rsp_valid rises.
   task automatic run_vec(input vec_t v, input int ws, input int hold);
      int   cyc;
      int   en_cyc;
      int   en_cnt;
      logic seen;
      ram_word = v.ram;
      @(negedge clk);
      chk("req_ready_idle", {31'b0, m_req_ready}, 32'd1);
      drive_req(v);
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0; en_cyc = -1; en_cnt = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (m_en) begin
            en_cnt++;
            en_cyc = cyc;
            chk("mem_we", {28'b0, m_we}, {28'b0, v.exp_we});
            chk("mem_wdata", m_wdata, v.exp_wdata);
            chk("mem_addr", {2'b0, m_addr}, {2'b0, v.exp_maddr});
         end
         if (m_rsp_valid) seen = 1'b1;
      end
      chk("rsp_seen", {31'b0, seen}, 32'd1);
      chk("rsp_latency", cyc, ws + 3);
      chk("mem_en_cycle", en_cyc, ws + 1);
      chk("mem_en_count", en_cnt, 1);
      chk("rsp_rdata", m_rsp_rdata, v.exp_rdata);
      chk("rsp_fault", {31'b0, m_rsp_fault}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_rsp_valid", {31'b0, m_rsp_valid}, 32'd1);
         chk("hold_rsp_rdata", m_rsp_rdata, v.exp_rdata);
         chk("hold_req_ready", {31'b0, m_req_ready}, 32'd0);
         chk("hold_mem_en", {31'b0, m_en}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("post_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
      chk("post_req_ready", {31'b0, m_req_ready}, 32'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t v;
      logic bad;
      //          wr  addr          wdata         be       sz    sgn  ram           we       wdata         maddr   rdata
      vecs[0] = '{1'b1, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 2'd0, 1'b0, 32'hDEAD_BEEF, 4'b1000, 32'hA5A5_A5A5, 30'h40, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0103, 32'h0,         4'b1000, 2'd0, 1'b1, 32'h8011_2233, 4'b0000, 32'h0,         30'h40, 32'hFFFF_FF80};
      vecs[2] = '{1'b0, 32'h0000_0103, 32'h0,         4'b1000, 2'd0, 1'b0, 32'h8011_2233, 4'b0000, 32'h0,         30'h40, 32'h0000_0080};
      vecs[3] = '{1'b0, 32'h0000_0002, 32'h0,         4'b1100, 2'd1, 1'b1, 32'h7FFF_1234, 4'b0000, 32'h0,         30'h0,  32'h0000_7FFF};
      vecs[4] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0011, 2'd1, 1'b1, 32'h7FFF_1234, 4'b0000, 32'h0,         30'h0,  32'h0000_1234};
      vecs[5] = '{1'b0, 32'h0000_0002, 32'h0,         4'b1100, 2'd1, 1'b1, 32'h8000_5678, 4'b0000, 32'h0,         30'h0,  32'hFFFF_8000};
      vecs[6] = '{1'b0, 32'h0000_0011, 32'h0,         4'b0010, 2'd0, 1'b1, 32'h1122_8344, 4'b0000, 32'h0,         30'h4,  32'hFFFF_FF83};
      vecs[7] = '{1'b0, 32'h0000_0020, 32'h0,         4'b1111, 2'd2, 1'b1, 32'h89AB_CDEF, 4'b0000, 32'h0,         30'h8,  32'h89AB_CDEF};
      vecs[8] = '{1'b1, 32'h0000_000A, 32'h0000_BEEF, 4'b1100, 2'd1, 1'b0, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 30'h2,  32'h0};
      vecs[9] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'b1111, 2'd2, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h1234_5678, 30'h1,  32'h0};

      // clock / reset
      sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_be = '0; req_size = '0; req_signed = 1'b0;
      rsp_ready = 1'b0; ram_word = '0; reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready_a}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_a, 32'd0);
      chk("rst_rsp_fault", {31'b0, rsp_fault_a}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en_a}, 32'd0);
      chk("rst_mem_we", {28'b0, mem_we_a}, 32'd0);
      chk("rst_state", {30'b0, dbg_state_a}, 32'd0);

      // table-driven transactions, zero wait states
      for (int i = 0; i < 10; i++)
         run_vec(vecs[i], 0, (i == 1) ? 2 : 0);

      // three wait states, word load with 5 cycles of back-pressure
      sel = 1'b1;
      v = '{1'b0, 32'h0000_0030, 32'h0, 4'b1111, 2'd2, 1'b1, 32'hCAFE_F00D,
            4'b0000, 32'h0, 30'hC, 32'hCAFE_F00D};
      run_vec(v, 3, 5);
      sel = 1'b0;

      // reset while the strobe is pending in ACCESS
      v = '{1'b0, 32'h0000_0040, 32'h0, 4'b1111, 2'd2, 1'b0, 32'h1111_2222,
            4'b0000, 32'h0, 30'h10, 32'h0};
      @(negedge clk);
      drive_req(v);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_mem_en", {31'b0, m_en}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_mem_en", {31'b0, m_en}, 32'd0);
      chk("midrst_mem_we", {28'b0, m_we}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("postrst_rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
      chk("postrst_req_ready", {31'b0, m_req_ready}, 32'd1);
      chk("postrst_state", {30'b0, m_state}, 32'd0);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (m_en || m_rsp_valid) bad = 1'b1;
      end
      chk("postrst_quiet", {31'b0, bad}, 32'd0);

      // misaligned half store to 0x001
      v = '{1'b1, 32'h0000_0001, 32'h0000_1234, 4'b0011, 2'd1, 1'b0, 32'hDEAD_BEEF,
            4'b0011, 32'h1234_1234, 30'h0, 32'h0};
`ifdef MEM_MISALIGN_FAULT_EN
      @(negedge clk);
      drive_req(v);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mis_mem_en", {31'b0, m_en}, 32'd0);
      chk("mis_rsp_valid", {31'b0, m_rsp_valid}, 32'd1);
      chk("mis_rsp_fault", {31'b0, m_rsp_fault}, 32'd1);
      chk("mis_rsp_rdata", m_rsp_rdata, 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("mis_mem_en_after", {31'b0, m_en}, 32'd0);
      chk("mis_req_ready", {31'b0, m_req_ready}, 32'd1);
`else
      run_vec(v, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_lane_ctrl.md
# mem_lane_ctrl

Data-memory access controller sitting directly downstream of the byte-enable generator in the load/store path. It accepts one load or store per handshake together with its 4-bit lane enables. It sequences the synchronous word-wide data RAM with optional wait states. It returns lane-extracted, zero- or sign-extended load data through a registered response handshake.

## Interface
Parameters:
- WAIT_STATES, default 0: extra idle cycles inserted before the RAM strobe (0–15).
- CNT_W, default 4: wait-state counter width.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; [31:2] is the word index, [1:0] is the lane offset.
- req_wdata  input  32  store data, right-justified.
- req_be  input  4  lane enables from the byte-enable stage.
- req_size  input  2  0 = byte, 1 = half, 2/3 = word (same codes as the enable stage).
- req_signed  input  1  sign-extend loads.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer takes response.
- rsp_rdata  output  32  extended load data (0 for stores).
- rsp_fault  output  1  misalignment fault (see Configuration).
- mem_en  output  1  RAM access strobe, one cycle.
- mem_we  output  4  per-lane write enables.
- mem_addr  output  30  word address.
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  RAM read data, valid the cycle after mem_en.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, be, size, signed, write; load cnt=WAIT_STATES; go to ACCESS.
- ACCESS: req_ready=0. If cnt≠0, decrement. At cnt==0, assert mem_en; assert mem_we=be_q if write, else 0; go to CAPTURE.
- CAPTURE: extract from mem_rdata into rdata_q; go to RESP.
- RESP: rsp_valid=1; rsp_rdata/rsp_fault stable. On rsp_ready, go to IDLE. Next request is accepted no earlier than the following cycle; no overlap.
- Store data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extraction: byte selects lane addr_q[1:0]; half selects addr_q[1] (0 → [15:0], 1 → [31:16]); word returns the full word.
- Extension: zero-extend unless signed_q, then replicate the MSB of the selected byte/half. Word loads ignore signed.
- mem_addr = addr_q[31:2]; mem_wdata driven from latched data whenever not IDLE.
- Stores still produce a response, with rdata=0.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_en=0, mem_we=0, cnt=0.
- Latency, accept edge to rsp_valid: WAIT_STATES+3 cycles. With WAIT_STATES=0: accept at cycle 0, mem_en in cycle 1, capture in cycle 2, rsp_valid in cycle 3.
- mem_en is high for exactly one cycle per request.
- rsp_valid held with stable data until rsp_ready; back-pressure is unbounded.
- Reset mid-operation returns to IDLE immediately. A pending strobe is dropped: mem_en/mem_we go 0 in the reset cycle. No response is issued.
- req_valid is ignored outside IDLE; the requester must hold the request until req_ready.

## Configuration
- MEM_MISALIGN_FAULT_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, takes IDLE→RESP directly.
  - mem_en stays 0, rsp_fault=1, rsp_rdata=0.
- Undefined:
  - Unused offset bits are ignored (half uses addr[1], word ignores [1:0]).
  - rsp_fault is tied 0.

## Structure
- Shared package mem_pkg: size codes SIZE_BYTE/HALF/WORD, FSM state enum, lane-replicate and extend functions.
- One sub-module: load_extract (combinational; mem_rdata, offset, size, signed → 32-bit result), reusable by the writeback stage.

## Test plan
- Reset, then byte store 0xA5 to addr 0x103 with be=1000:
  - mem_we=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x40.
  - rsp_valid exactly 3 cycles after accept.
- Signed byte load from 0x103 with RAM word 0x80112233 → rsp_rdata=0xFFFFFF80. Unsigned → 0x00000080.
- Half load from 0x002 with RAM word 0x7FFF1234: signed → 0x00007FFF; from 0x000 signed → 0x00001234.
- WAIT_STATES=3, word load:
  - mem_en asserted 4 cycles after accept.
  - Hold rsp_ready=0 for 5 cycles; data stays stable and req_ready stays 0.
- Assert reset in the ACCESS cycle: no mem_en, rsp_valid=0, req_ready=1 next cycle.
- With MEM_MISALIGN_FAULT_EN, half store to 0x001: mem_en never asserts, rsp_fault=1 after 1 cycle. Without it, mem_we=0011.
